uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per serial bit (100 MHz / 115200 baud); legal range >= 2.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, byte entries; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port tx_data  input  8  byte to enqueue.
REQ-006 SHALL have port tx_data_valid  input  1  enqueue request, qualified by tx_ready.
REQ-007 SHALL have port tx_ready  output  1  FIFO can accept a byte this cycle.
REQ-008 SHALL have port tx  output  1  serial line, 8N1, LSB first, idle high.
REQ-009 SHALL have port busy  output  1  a frame is being shifted or the FIFO is non-empty.
REQ-010 SHALL have port level  output  $clog2(FIFO_DEPTH)+1  bytes held in FIFO, excluding the byte in the shifter.

Function
REQ-011 SHALL drive tx_ready combinationally as (level < FIFO_DEPTH).
REQ-012 SHALL enqueue tx_data on a clock edge iff tx_data_valid && tx_ready; when tx_ready=0, tx_data_valid is ignored and the byte is dropped without error.
REQ-013 SHALL implement the FIFO as a circular buffer with read/write pointers that wrap modulo FIFO_DEPTH.
REQ-014 SHALL use a transmit FSM with states IDLE, START, DATA, STOP, a bit-period counter (0..CLKS_PER_BIT-1) and a bit index (0..7).
REQ-015 IDLE: tx=1; if level>0, pop head into the shift register and enter START on the next edge.
REQ-016 START: tx=0 for exactly CLKS_PER_BIT cycles, then DATA with bit index 0.
REQ-017 DATA: tx = shift[bit index] for CLKS_PER_BIT cycles per bit, index 0 to 7, then STOP.
REQ-018 STOP: tx=1 for CLKS_PER_BIT cycles; on its last cycle, if level>0 pop and enter START directly (no idle cycle), else enter IDLE.
REQ-019 A complete frame SHALL occupy exactly 10*CLKS_PER_BIT cycles on tx; back-to-back frames SHALL have no gap.
REQ-020 The first byte pushed into an empty idle block SHALL produce the tx falling edge 2 cycles after the push edge: the push edge, the pop edge, then START.
REQ-021 Simultaneous push and pop in one cycle SHALL leave level unchanged and preserve FIFO order.
REQ-022 A push while full SHALL be impossible because tx_ready=0; a pop while empty SHALL never occur.
REQ-023 tx SHALL be driven from a register so it is glitch-free.
REQ-024 busy SHALL equal (state != IDLE) || (level != 0).

Reset
REQ-025 rst_n=0 at an edge SHALL set state=IDLE, tx=1, pointers=0, level=0, counters=0, busy=0, tx_ready=1.
REQ-026 Reset mid-frame SHALL abort the frame with tx=1 on the next edge and discard all FIFO contents; FIFO storage contents need not be cleared.
REQ-027 No output SHALL be X after the first reset edge.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-028 Push 0xA5 once from idle -> tx low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles; 40 cycles total; busy falls after the stop bit.
REQ-029 Push 0x01,0x02,0x03 on consecutive cycles -> three frames of 40 cycles each with no idle gap; level sequence 1,1,2, then draining to 0.
REQ-030 Hold tx_data_valid=1 with incrementing data from reset -> tx_ready falls when level=4; the extra byte is dropped; the serial output shows bytes 0..4 in order (one in the shifter plus four queued).
REQ-031 With level=4 and the shifter in STOP, push on the pop cycle -> push is rejected (tx_ready=0); on the next cycle tx_ready=1 and the next push is accepted; order is kept.
REQ-032 Assert rst_n=0 during DATA bit 3 -> the next edge gives tx=1, level=0, busy=0; the byte pushed after release transmits a clean frame.
REQ-033 Run 6 frames through the depth-4 FIFO -> pointer wrap gives correct byte order with no loss or duplication.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter (LSB first, idle high).
// The serial line is a registered decode of the FSM state, so tx lags the state by one cycle.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_data_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         r_state;
    logic [7:0]     r_mem [FIFO_DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [LW-1:0]  r_level;
    logic [CW-1:0]  r_clk_cnt;
    logic [2:0]     r_bit_idx;
    logic [7:0]     r_shift;
    logic           r_tx;

    logic           w_push;
    logic           w_pop;
    logic           w_bit_done;
    logic           w_fifo_nempty;

    assign w_fifo_nempty = (r_level != '0);
    assign w_bit_done    = (r_clk_cnt == CW'(CLKS_PER_BIT - 1));
    assign tx_ready      = (r_level < LW'(FIFO_DEPTH));
    assign w_push        = tx_data_valid && tx_ready;
    // Pop from IDLE, or on the last stop-bit cycle so the next frame follows with no gap
    assign w_pop         = w_fifo_nempty &&
                           ((r_state == IDLE) || ((r_state == STOP) && w_bit_done));

    assign tx    = r_tx;
    assign busy  = (r_state != IDLE) || w_fifo_nempty;
    assign level = r_level;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
        if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_tx      <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx      <= 1'b1;
                    r_clk_cnt <= '0;
                    r_bit_idx <= '0;
                    if (w_pop) begin
                        r_state <= START;
                    end
                end
                START: begin
                    r_tx <= 1'b0;
                    if (w_bit_done) begin
                        r_clk_cnt <= '0;
                        r_bit_idx <= '0;
                        r_state   <= DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                DATA: begin
                    r_tx <= r_shift[r_bit_idx];
                    if (w_bit_done) begin
                        r_clk_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_bit_idx <= '0;
                            r_state   <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                STOP: begin
                    r_tx <= 1'b1;
                    if (w_bit_done) begin
                        r_clk_cnt <= '0;
                        r_state   <= w_pop ? START : IDLE;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A negedge-sampling serial receiver collects decoded bytes and frame start times.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_data_valid = 1'b0;
    logic       tx_ready;
    logic       tx;
    logic       busy;
    logic [2:0] level;

    int n_assert = 0;
    int n_fail   = 0;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_ready      (tx_ready),
        .tx            (tx),
        .busy          (busy),
        .level         (level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Serial receiver: frame start is the first low sample, bits sampled mid-period
    logic [7:0] rx_q[$];
    int         st_q[$];
    bit         m_active = 1'b0;
    int         m_cnt = 0;
    int         m_start = 0;
    logic [7:0] m_byte = 8'h00;
    int         m_stop_err = 0;
    int         m_start_err = 0;

    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (tx === 1'b0) begin
                m_active = 1'b1;
                m_cnt    = 0;
                m_start  = cyc;
            end
        end else begin
            m_cnt++;
            if (m_cnt % CPB == CPB / 2) begin
                if (m_cnt / CPB == 0) begin
                    if (tx !== 1'b0) m_start_err++;
                end else if (m_cnt / CPB == 9) begin
                    if (tx !== 1'b1) m_stop_err++;
                    rx_q.push_back(m_byte);
                    st_q.push_back(m_start);
                    m_active = 1'b0;
                end else begin
                    m_byte[m_cnt / CPB - 1] = tx;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_rx(input int n, input string tag);
        int b;
        b = 0;
        while (rx_q.size() < n && b < 3000) begin
            step(1);
            b++;
        end
        chk(tag, rx_q.size(), n);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tx_data_valid = 1'b0;
        step(2);
        rst_n = 1'b1;
        rx_q.delete();
        st_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] vec33 [6];
    logic [7:0] a5;
    logic       exp_tx;
    int         b;

    initial begin
        vec33 = '{8'hC3, 8'h3C, 8'h81, 8'h7E, 8'h00, 8'hFF};
        a5    = 8'hA5;

        // Reset state
        rst_n = 1'b0;
        step(2);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ready", tx_ready, 1);
        chk("rst_level", level, 0);
        rst_n = 1'b1;
        step(1);

        // Single 0xA5 frame: push edge, pop edge, then 40 cycles of frame on tx
        tx_data = 8'hA5;
        tx_data_valid = 1'b1;
        step(1);
        tx_data_valid = 1'b0;
        chk("a5_level_push", level, 1);
        chk("a5_tx_push", tx, 1);
        step(1);
        chk("a5_level_pop", level, 0);
        chk("a5_tx_pop", tx, 1);
        chk("a5_busy_pop", busy, 1);
        for (int k = 0; k < 40; k++) begin
            step(1);
            if (k < 4)       exp_tx = 1'b0;
            else if (k < 36) exp_tx = a5[(k - 4) / 4];
            else             exp_tx = 1'b1;
            chk($sformatf("a5_wave_%0d", k), tx, exp_tx);
            if (k == 37) chk("a5_busy_stop", busy, 1);
        end
        step(1);
        chk("a5_tx_after", tx, 1);
        chk("a5_busy_after", busy, 0);
        wait_rx(1, "a5_rx_count");
        chk("a5_rx_byte", rx_q[0], 8'hA5);
        rx_q.delete();
        st_q.delete();

        // Three consecutive pushes: level 1,1,2 then back-to-back frames
        tx_data_valid = 1'b1;
        tx_data = 8'h01;
        step(1);
        chk("b2b_level0", level, 1);
        tx_data = 8'h02;
        step(1);
        chk("b2b_level1", level, 1);
        tx_data = 8'h03;
        step(1);
        chk("b2b_level2", level, 2);
        tx_data_valid = 1'b0;
        wait_rx(3, "b2b_rx_count");
        chk("b2b_byte0", rx_q[0], 8'h01);
        chk("b2b_byte1", rx_q[1], 8'h02);
        chk("b2b_byte2", rx_q[2], 8'h03);
        chk("b2b_gap01", st_q[1] - st_q[0], 40);
        chk("b2b_gap12", st_q[2] - st_q[1], 40);
        step(4);
        chk("b2b_level_end", level, 0);
        chk("b2b_busy_end", busy, 0);

        // Continuous valid from reset: fill to 4, drop extras, then push on the pop cycle
        do_reset();
        tx_data_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tx_data = 8'(i);
            step(1);
            if (i == 0) chk("fill_level_first", level, 1);
            if (i == 4) begin
                chk("fill_level_full", level, 4);
                chk("fill_ready_full", tx_ready, 0);
            end
        end
        tx_data_valid = 1'b0;
        step(33);
        chk("popcyc_level_before", level, 4);
        chk("popcyc_ready_before", tx_ready, 0);
        tx_data_valid = 1'b1;
        tx_data = 8'h77;
        step(1);
        chk("popcyc_level_after", level, 3);
        chk("popcyc_ready_after", tx_ready, 1);
        tx_data = 8'h55;
        step(1);
        tx_data_valid = 1'b0;
        chk("popcyc_level_refill", level, 4);
        wait_rx(6, "fill_rx_count");
        for (int i = 0; i < 5; i++) chk($sformatf("fill_byte%0d", i), rx_q[i], 8'(i));
        chk("popcyc_byte5", rx_q[5], 8'h55);
        step(60);
        chk("fill_no_extra", rx_q.size(), 6);
        chk("fill_busy_end", busy, 0);

        // Reset during data bit 3 aborts the frame and empties the FIFO
        do_reset();
        tx_data_valid = 1'b1;
        tx_data = 8'h37;
        step(1);
        tx_data = 8'h99;
        step(1);
        tx_data_valid = 1'b0;
        chk("abort_level_pushpop", level, 1);
        step(17);
        chk("abort_tx_bit3", tx, 0);
        rst_n = 1'b0;
        step(1);
        chk("abort_tx", tx, 1);
        chk("abort_level", level, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", tx_ready, 1);
        rst_n = 1'b1;
        rx_q.delete();
        st_q.delete();
        step(1);
        tx_data_valid = 1'b1;
        tx_data = 8'h5A;
        step(1);
        tx_data_valid = 1'b0;
        wait_rx(1, "abort_rx_count");
        chk("abort_rx_byte", rx_q[0], 8'h5A);
        step(60);
        chk("abort_no_extra", rx_q.size(), 1);

        // Six frames through the depth-4 FIFO exercise pointer wrap
        rx_q.delete();
        st_q.delete();
        for (int i = 0; i < 6; i++) begin
            b = 0;
            while (!tx_ready && b < 500) begin
                step(1);
                b++;
            end
            tx_data_valid = 1'b1;
            tx_data = vec33[i];
            step(1);
            tx_data_valid = 1'b0;
        end
        wait_rx(6, "wrap_rx_count");
        for (int i = 0; i < 6; i++) chk($sformatf("wrap_byte%0d", i), rx_q[i], vec33[i]);
        step(60);
        chk("wrap_no_extra", rx_q.size(), 6);
        chk("wrap_level_end", level, 0);
        chk("wrap_busy_end", busy, 0);

        chk("frame_stop_errors", m_stop_err, 0);
        chk("frame_start_errors", m_start_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
